// File: rtl/morra_tabellone.sv
// morra_tabellone: scoreboard downstream of the MorraCinese game FSM.
// Keeps saturating per-player/tie/invalid tallies, the current win streak,
// latches the match outcome and strobes fine_pulse once per match.
// Optional feature: define MORRA_STORIA_EN to build the round-history shift
// register on storia; otherwise storia is tied to 0.
module morra_tabellone #(
  parameter int unsigned W_CNT      = 4,
  parameter int unsigned HIST_DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    inizio,
  input  logic [1:0]              manche,
  input  logic [1:0]              partita,
  output logic [W_CNT-1:0]        vinte_primo,
  output logic [W_CNT-1:0]        vinte_secondo,
  output logic [W_CNT-1:0]        pareggi,
  output logic [W_CNT-1:0]        invalide,
  output logic [W_CNT:0]          manche_giocate,
  output logic [1:0]              serie_chi,
  output logic [2:0]              serie_len,
  output logic                    fine,
  output logic [1:0]              vincitore,
  output logic                    fine_pulse,
  output logic [2*HIST_DEPTH-1:0] storia
);

  typedef enum logic {StGioco, StFine} state_e;

  state_e              state_q, state_d;
  logic                rel_q;
  logic [W_CNT-1:0]    vp_q, vp_d, vs_q, vs_d, par_q, par_d, inv_q, inv_d;
  logic [W_CNT:0]      mg_q, mg_d;
  logic [1:0]          chi_q, chi_d, vinc_q, vinc_d;
  logic [2:0]          len_q, len_d;
  logic                pulse_q, pulse_d;
`ifdef MORRA_STORIA_EN
  logic [2*HIST_DEPTH-1:0] storia_q, storia_d;
`endif

  function automatic logic [W_CNT-1:0] sat_inc(input logic [W_CNT-1:0] v);
    return (&v) ? v : v + W_CNT'(1);
  endfunction

  function automatic logic [W_CNT:0] sat_inc_mg(input logic [W_CNT:0] v);
    return (&v) ? v : v + (W_CNT+1)'(1);
  endfunction

  function automatic logic [2:0] sat_inc_len(input logic [2:0] v);
    return (&v) ? v : v + 3'd1;
  endfunction

  // Reset release stage: counting is held off for the first edge after rst_n
  // rises, so rel_q and the state flops behind it form the release path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rel_q <= 1'b0;
    else        rel_q <= 1'b1;
  end

  // Next-state: inizio clear has priority; counting only in StGioco.
  always_comb begin
    state_d = state_q;
    vp_d    = vp_q;
    vs_d    = vs_q;
    par_d   = par_q;
    inv_d   = inv_q;
    mg_d    = mg_q;
    chi_d   = chi_q;
    len_d   = len_q;
    vinc_d  = vinc_q;
    pulse_d = 1'b0;
`ifdef MORRA_STORIA_EN
    storia_d = storia_q;
`endif
    if (rel_q) begin
      if (inizio) begin
        state_d = StGioco;
        vp_d    = '0;
        vs_d    = '0;
        par_d   = '0;
        inv_d   = '0;
        mg_d    = '0;
        chi_d   = 2'b00;
        len_d   = 3'd0;
        vinc_d  = 2'b00;
`ifdef MORRA_STORIA_EN
        storia_d = '0;
`endif
      end else if (state_q == StGioco) begin
        unique case (manche)
          2'b01: begin
            vp_d = sat_inc(vp_q);
            mg_d = sat_inc_mg(mg_q);
            if (chi_q == 2'b01) begin
              len_d = sat_inc_len(len_q);
            end else begin
              chi_d = 2'b01;
              len_d = 3'd1;
            end
          end
          2'b10: begin
            vs_d = sat_inc(vs_q);
            mg_d = sat_inc_mg(mg_q);
            if (chi_q == 2'b10) begin
              len_d = sat_inc_len(len_q);
            end else begin
              chi_d = 2'b10;
              len_d = 3'd1;
            end
          end
          2'b11: begin
            par_d = sat_inc(par_q);
            mg_d  = sat_inc_mg(mg_q);
            chi_d = 2'b00;
            len_d = 3'd0;
          end
          default: inv_d = sat_inc(inv_q);
        endcase
`ifdef MORRA_STORIA_EN
        if (manche != 2'b00) storia_d = {storia_q[2*HIST_DEPTH-3:0], manche};
`endif
        // The deciding round is counted above in the same cycle.
        if (partita != 2'b00) begin
          state_d = StFine;
          vinc_d  = partita;
          pulse_d = 1'b1;
        end
      end
    end
  end

  // State and scoreboard registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StGioco;
      vp_q    <= '0;
      vs_q    <= '0;
      par_q   <= '0;
      inv_q   <= '0;
      mg_q    <= '0;
      chi_q   <= 2'b00;
      len_q   <= 3'd0;
      vinc_q  <= 2'b00;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vp_q    <= vp_d;
      vs_q    <= vs_d;
      par_q   <= par_d;
      inv_q   <= inv_d;
      mg_q    <= mg_d;
      chi_q   <= chi_d;
      len_q   <= len_d;
      vinc_q  <= vinc_d;
      pulse_q <= pulse_d;
    end
  end

`ifdef MORRA_STORIA_EN
  // Round history register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) storia_q <= '0;
    else        storia_q <= storia_d;
  end
  assign storia = storia_q;
`else
  assign storia = '0;
`endif

  assign vinte_primo    = vp_q;
  assign vinte_secondo  = vs_q;
  assign pareggi        = par_q;
  assign invalide       = inv_q;
  assign manche_giocate = mg_q;
  assign serie_chi      = chi_q;
  assign serie_len      = len_q;
  assign fine           = (state_q == StFine);
  assign vincitore      = vinc_q;
  assign fine_pulse     = pulse_q;

endmodule

// File: tb/tb_morra_tabellone.sv
// Self-checking bench for morra_tabellone: behavioural scoreboard model,
// per-cycle compare process, directed literal checks and random stimulus.
module tb_morra_tabellone;

  localparam int W    = 4;
  localparam int HD   = 8;
  localparam int MAXC = (1 << W) - 1;
  localparam int MAXG = (1 << (W + 1)) - 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            inizio = 1'b0;
  logic [1:0]      manche = 2'b00;
  logic [1:0]      partita = 2'b00;
  logic [W-1:0]    vinte_primo, vinte_secondo, pareggi, invalide;
  logic [W:0]      manche_giocate;
  logic [1:0]      serie_chi, vincitore;
  logic [2:0]      serie_len;
  logic            fine, fine_pulse;
  logic [2*HD-1:0] storia;

  int tests = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  morra_tabellone #(.W_CNT(W), .HIST_DEPTH(HD)) dut (
    .clk(clk), .rst_n(rst_n), .inizio(inizio), .manche(manche), .partita(partita),
    .vinte_primo(vinte_primo), .vinte_secondo(vinte_secondo), .pareggi(pareggi),
    .invalide(invalide), .manche_giocate(manche_giocate), .serie_chi(serie_chi),
    .serie_len(serie_len), .fine(fine), .vincitore(vincitore),
    .fine_pulse(fine_pulse), .storia(storia)
  );

  always #5 clk = ~clk;

  // Behavioural model of the scoreboard.
  int m_vp, m_vs, m_par, m_inv, m_mg, m_chi, m_len, m_fine, m_vinc, m_pulse;
  bit m_armed;
  logic [2*HD-1:0] m_hist;

  function automatic int capped(input int v, input int cap);
    return (v < cap) ? v + 1 : cap;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_vp <= 0; m_vs <= 0; m_par <= 0; m_inv <= 0; m_mg <= 0;
      m_chi <= 0; m_len <= 0; m_fine <= 0; m_vinc <= 0; m_pulse <= 0;
      m_hist <= '0; m_armed <= 1'b0;
    end else if (!m_armed) begin
      m_armed <= 1'b1;
      m_pulse <= 0;
    end else if (inizio) begin
      m_vp <= 0; m_vs <= 0; m_par <= 0; m_inv <= 0; m_mg <= 0;
      m_chi <= 0; m_len <= 0; m_fine <= 0; m_vinc <= 0; m_pulse <= 0;
      m_hist <= '0;
    end else if (m_fine != 0) begin
      m_pulse <= 0;
    end else begin
      if (manche == 2'b00) begin
        m_inv <= capped(m_inv, MAXC);
      end else begin
        m_mg <= capped(m_mg, MAXG);
        m_hist <= {m_hist[2*HD-3:0], manche};
        if (manche == 2'b11) begin
          m_par <= capped(m_par, MAXC);
          m_chi <= 0;
          m_len <= 0;
        end else begin
          if (manche == 2'b01) m_vp <= capped(m_vp, MAXC);
          else                 m_vs <= capped(m_vs, MAXC);
          m_chi <= int'(manche);
          m_len <= (m_chi == int'(manche)) ? capped(m_len, 7) : 1;
        end
      end
      if (partita != 2'b00) begin
        m_fine <= 1;
        m_vinc <= int'(partita);
        m_pulse <= 1;
      end else begin
        m_pulse <= 0;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("vinte_primo", int'(vinte_primo), m_vp);
      chk("vinte_secondo", int'(vinte_secondo), m_vs);
      chk("pareggi", int'(pareggi), m_par);
      chk("invalide", int'(invalide), m_inv);
      chk("manche_giocate", int'(manche_giocate), m_mg);
      chk("serie_chi", int'(serie_chi), m_chi);
      chk("serie_len", int'(serie_len), m_len);
      chk("fine", int'(fine), m_fine);
      chk("vincitore", int'(vincitore), m_vinc);
      chk("fine_pulse", int'(fine_pulse), m_pulse);
`ifdef MORRA_STORIA_EN
      chk("storia", int'(storia), int'(m_hist));
`else
      chk("storia", int'(storia), 0);
`endif
    end
  end

  task automatic step(input logic i, input logic [1:0] m, input logic [1:0] p);
    inizio = i;
    manche = m;
    partita = p;
    @(negedge clk);
  endtask

  int pulses;

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_vp", int'(vinte_primo), 0);
    chk("reset_fine", int'(fine), 0);
    cmp_en = 1'b1;

    // Reset release: first edge only arms, second edge counts.
    rst_n = 1'b1;
    step(1'b0, 2'b01, 2'b00);
    chk("release_first_edge", int'(vinte_primo), 0);
    step(1'b0, 2'b01, 2'b00);
    chk("release_second_edge", int'(vinte_primo), 1);
    step(1'b0, 2'b01, 2'b00);
    chk("vp_before_reset", int'(vinte_primo), 2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_vp", int'(vinte_primo), 0);
    chk("async_reset_mg", int'(manche_giocate), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 2'b00, 2'b00);
    step(1'b0, 2'b01, 2'b00);
    chk("after_reset_vp", int'(vinte_primo), 1);

    // Three straight primo wins.
    step(1'b1, 2'b00, 2'b00);
    step(1'b0, 2'b01, 2'b00);
    step(1'b0, 2'b01, 2'b00);
    step(1'b0, 2'b01, 2'b01);
    chk("p3_vp", int'(vinte_primo), 3);
    chk("p3_len", int'(serie_len), 3);
    chk("p3_chi", int'(serie_chi), 1);
    chk("p3_mg", int'(manche_giocate), 3);
    chk("p3_fine", int'(fine), 1);
    chk("p3_vinc", int'(vincitore), 1);
    chk("p3_pulse", int'(fine_pulse), 1);
    step(1'b0, 2'b10, 2'b00);
    chk("p3_pulse_drop", int'(fine_pulse), 0);
    chk("p3_frozen_vs", int'(vinte_secondo), 0);

    // inizio priority over a deciding round.
    step(1'b1, 2'b01, 2'b01);
    chk("iniz_fine", int'(fine), 0);
    chk("iniz_pulse", int'(fine_pulse), 0);
    chk("iniz_vp", int'(vinte_primo), 0);
    step(1'b0, 2'b10, 2'b00);
    chk("iniz_next_vs", int'(vinte_secondo), 1);

    // Mixed match.
    step(1'b1, 2'b00, 2'b00);
    step(1'b0, 2'b01, 2'b00);
    step(1'b0, 2'b10, 2'b00);
    step(1'b0, 2'b11, 2'b00);
    step(1'b0, 2'b00, 2'b00);
    step(1'b0, 2'b10, 2'b00);
    chk("mix_vp", int'(vinte_primo), 1);
    chk("mix_vs", int'(vinte_secondo), 2);
    chk("mix_par", int'(pareggi), 1);
    chk("mix_inv", int'(invalide), 1);
    chk("mix_mg", int'(manche_giocate), 4);
    chk("mix_chi", int'(serie_chi), 2);
    chk("mix_len", int'(serie_len), 1);
`ifdef MORRA_STORIA_EN
    chk("mix_storia", int'(storia[7:0]), 8'b01_10_11_10);
`endif

    // Saturation.
    step(1'b1, 2'b00, 2'b00);
    repeat (20) step(1'b0, 2'b01, 2'b00);
    chk("sat_vp", int'(vinte_primo), 15);
    chk("sat_len", int'(serie_len), 7);
    chk("sat_mg20", int'(manche_giocate), 20);
    repeat (15) step(1'b0, 2'b01, 2'b00);
    chk("sat_mg31", int'(manche_giocate), 31);

    // Restart after a drawn match.
    step(1'b1, 2'b00, 2'b00);
    step(1'b0, 2'b11, 2'b11);
    chk("draw_vinc", int'(vincitore), 3);
    chk("draw_pulse", int'(fine_pulse), 1);
    step(1'b1, 2'b00, 2'b00);
    chk("restart_fine", int'(fine), 0);
    chk("restart_par", int'(pareggi), 0);
    chk("restart_vinc", int'(vincitore), 0);
    step(1'b0, 2'b01, 2'b10);
    chk("restart_pulse", int'(fine_pulse), 1);
    chk("restart_vinc2", int'(vincitore), 2);

    // Random traffic checked by the compare process; count pulses per match.
    pulses = 0;
    for (int n = 0; n < 3000; n++) begin
      if (rst_n == 1'b0) rst_n = 1'b1;
      else if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
      inizio  = ($urandom_range(0, 15) == 0);
      manche  = 2'($urandom_range(0, 3));
      partita = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      @(negedge clk);
      if (fine_pulse) pulses++;
      if (inizio || !rst_n) pulses = 0;
      if (pulses > 1) begin
        chk("single_pulse_per_match", pulses, 1);
        pulses = 1;
      end
    end

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
